// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the execute stage.
// Operands are taken as magnitudes and the sign is fixed up at the end.
// Multiply uses shift-add. Divide uses restoring shift-subtract.
// Each operation takes one iteration per operand bit.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   data_operandA   multiplicand / dividend (signed)
//   data_operandB   multiplier / divisor (signed)
//   ctrl_MULT       start pulse, multiply (wins over ctrl_DIV)
//   ctrl_DIV        start pulse, divide
//   data_result     low WIDTH bits of product, or quotient; held until next completion
//   data_exception  overflow / divide-by-zero, held with data_result
//   data_resultRDY  one-cycle completion pulse
//   busy            operation in flight (start edge through RDY cycle)
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // acc: 2W product accumulator, or {remainder, dividend->quotient} for divide
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     b_q, b_d;        // multiplier (shifts right) or divisor (static)
  logic                 sign_q, sign_d;
  logic                 dz_q, dz_d;      // divide by zero
  logic                 ovf_q, ovf_d;    // SMIN / -1
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 exc_q, exc_d;

  logic                 start, iter, fin;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sh;
  logic                 ge;
  logic [WIDTH-1:0]     rem_n;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot;

  assign start = ctrl_MULT | ctrl_DIV;
  assign iter  = (state_q == MUL || state_q == DIV) && cnt_q != LAST;
  assign fin   = (state_q == MUL || state_q == DIV) && cnt_q == LAST;

  // Magnitudes; SMIN negates to itself, which is its correct unsigned magnitude.
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Restoring divide step. When the trial subtraction succeeds the true
  // difference is below the divisor, so the low WIDTH bits carry it exactly.
  assign sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge    = sh >= {1'b0, b_q};
  assign rem_n = ge ? (sh[WIDTH-1:0] - b_q) : sh[WIDTH-1:0];

  assign prod  = sign_q ? -acc_q : acc_q;
  assign quot  = sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; a start in any state restarts the unit
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL, DIV: if (cnt_q == LAST) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = state_q;
    endcase
    if (ctrl_MULT)     state_d = MUL;
    else if (ctrl_DIV) state_d = DIV;
  end

  // Outputs
  always_comb begin
    data_resultRDY = (state_q == DONE);
    busy           = (state_q != IDLE);
    data_result    = res_q;
    data_exception = exc_q;
  end

  // Datapath next state
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    b_d     = b_q;
    sign_d  = sign_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (start) begin
      cnt_d  = '0;
      b_d    = b_mag;
      sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d   = (data_operandB == '0);
      ovf_d  = (data_operandA == SMIN) && (data_operandB == '1);
      if (ctrl_MULT) begin
        acc_d   = '0;
        mcand_d = {{WIDTH{1'b0}}, a_mag};
      end else begin
        acc_d   = {{WIDTH{1'b0}}, a_mag};
        mcand_d = '0;
      end
    end else if (iter) begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == MUL) begin
        acc_d   = acc_q + (b_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
      end else begin
        acc_d   = {rem_n, acc_q[WIDTH-2:0], ge};
      end
    end else if (fin) begin
      if (state_q == MUL) begin
        res_d = prod[WIDTH-1:0];
        exc_d = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
      end else begin
        exc_d = dz_q | ovf_q;
        res_d = (dz_q | ovf_q) ? '0 : quot;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
module tb_multdiv_iter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  multdiv_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          at;
  } exp_t;
  exp_t sb[$];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: every RDY pulse must match the oldest outstanding expectation
  exp_t e;
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_rdy: got result %h at cycle %0d, expected no pulse", data_result, cyc);
      end else begin
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
        chk("latency", cyc, e.at);
      end
    end
  end

  // Pulse a start for one cycle; operands are scrambled afterwards to prove latching
  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] er, input bit ee);
    exp_t x;
    @(negedge clock);
    data_operandA = a; data_operandB = b; ctrl_MULT = m; ctrl_DIV = d;
    if (push) begin
      x.res = er; x.exc = ee; x.at = cyc + 34;
      sb.push_back(x);
    end
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_done(input bit check_busy);
    bit dropped = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock); #1;
      if (sb.size() == 0) break;
      if (!busy) dropped = 1'b1;
    end
    if (sb.size() != 0) begin
      chk("timeout", 32'd1, 32'd0);
      sb.delete();
    end
    if (check_busy) chk("busy_hold", {31'b0, dropped}, 32'd0);
    @(negedge clock); #1;
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'b0, data_exception}, 32'd0);
    chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clock); reset = 1'b1;

    issue(1, 0, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFEB, 0); wait_done(1);
    issue(1, 0, 32'h00010000, 32'h00010000, 1, 32'h00000000, 1); wait_done(1);
    issue(1, 0, 32'h80000000, 32'd1, 1, 32'h80000000, 0); wait_done(1);
    issue(0, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 0); wait_done(1);
    issue(0, 1, 32'd100, 32'd0, 1, 32'd0, 1); wait_done(1);
    issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 1); wait_done(1);

    // Abort: multiply superseded by a divide ten cycles later
    issue(1, 0, 32'd5, 32'd5, 0, 32'd0, 0);
    repeat (8) @(negedge clock);
    issue(0, 1, 32'd50, 32'd5, 1, 32'd10, 0); wait_done(0);
    repeat (5) @(negedge clock);

    // Both starts high: multiply wins
    issue(1, 1, 32'd6, 32'd3, 1, 32'd18, 0); wait_done(1);

    // Reset mid-operation
    issue(1, 0, 32'd9, 32'd9, 0, 32'd0, 0);
    repeat (14) @(negedge clock);
    reset = 1'b0; #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_result", data_result, 32'd0);
    chk("midrst_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("midrst_exc", {31'b0, data_exception}, 32'd0);
    @(negedge clock); reset = 1'b1;
    repeat (40) @(negedge clock);
    #1 chk("midrst_idle_result", data_result, 32'd0);

    issue(1, 0, 32'd2, 32'd2, 1, 32'd4, 0); wait_done(1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
